// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-entry pending (scoreboard) bit and pending counter.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data and pending state to the read ports.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [ADDR_W:0]   r_pendCnt;

    logic w_wrEn;
    logic w_rsvEn;
    logic w_cntInc;
    logic w_cntDec;

    // Entry 0 is immune to writes and reserves when hardwired to zero.
    assign w_wrEn  = rst_n && we  && !((ZERO_REG != 0) && (waddr == '0));
    assign w_rsvEn = rst_n && rsv && !((ZERO_REG != 0) && (rsv_addr == '0));

    assign w_cntInc = w_rsvEn && !r_pend[rsv_addr];
    assign w_cntDec = w_wrEn && r_pend[waddr] && !(w_rsvEn && (rsv_addr == waddr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reserve is applied after the clear so that it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            if (w_wrEn) begin
                r_pend[waddr] <= 1'b0;
            end
            if (w_rsvEn) begin
                r_pend[rsv_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pendCnt <= '0;
        end else begin
            case ({w_cntInc, w_cntDec})
                2'b10:   r_pendCnt <= r_pendCnt + CNT_ONE;
                2'b01:   r_pendCnt <= r_pendCnt - CNT_ONE;
                default: r_pendCnt <= r_pendCnt;
            endcase
        end
    end

    assign pend_cnt = r_pendCnt;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_isZero;

        assign w_addr   = raddr[gi*ADDR_W +: ADDR_W];
        assign w_isZero = (ZERO_REG != 0) && (w_addr == '0);

`ifdef REG_FILE_BYPASS_EN
        logic w_hit;
        logic w_rsvHit;

        // A forwarded entry is busy only if it is being re-reserved in the same cycle.
        assign w_hit    = w_wrEn && (waddr == w_addr);
        assign w_rsvHit = w_rsvEn && (rsv_addr == w_addr);

        assign rdata[gi*DATA_W +: DATA_W] = w_isZero ? '0 : (w_hit ? wdata : r_mem[w_addr]);
        assign busy[gi] = w_isZero ? 1'b0 : (w_hit ? w_rsvHit : r_pend[w_addr]);
`else
        assign rdata[gi*DATA_W +: DATA_W] = w_isZero ? '0 : r_mem[w_addr];
        assign busy[gi] = w_isZero ? 1'b0 : r_pend[w_addr];
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model of entries and pending bits.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     rsv;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        busy;
    logic [ADDR_W:0]          pend_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mdlMem  [DEPTH];
    bit                mdlPend [DEPTH];

    reg_file_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rsv     (rsv),
        .rsv_addr(rsv_addr),
        .raddr   (raddr),
        .rdata   (rdata),
        .busy    (busy),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    function automatic int mdlCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mdlPend[i]) n++;
        end
        return n;
    endfunction

    task automatic mdlReset();
        for (int i = 0; i < DEPTH; i++) begin
            mdlMem[i]  = '0;
            mdlPend[i] = 1'b0;
        end
    endtask

    // Expected read-side view of the current model state and current inputs.
    task automatic checkReads(input string tag);
        for (int p = 0; p < NUM_RD; p++) begin
            int          a;
            logic [31:0] expD;
            logic        expB;
            a = int'(raddr[p*ADDR_W +: ADDR_W]);
            if (a == 0) begin
                expD = '0;
                expB = 1'b0;
            end else begin
                expD = mdlMem[a];
                expB = mdlPend[a];
`ifdef REG_FILE_BYPASS_EN
                if (rst_n && we && int'(waddr) == a) begin
                    expD = wdata;
                    expB = rst_n && rsv && int'(rsv_addr) == a;
                end
`endif
            end
            checkOutput($sformatf("%s_rd%0d", tag, p), 64'(rdata[p*DATA_W +: DATA_W]), 64'(expD));
            checkOutput($sformatf("%s_busy%0d", tag, p), 64'(busy[p]), 64'(expB));
        end
        checkOutput($sformatf("%s_cnt", tag), 64'(pend_cnt), 64'(mdlCount()));
    endtask

    task automatic applyStimulus(input logic iWe, input logic [4:0] iWaddr, input logic [31:0] iWdata,
                                 input logic iRsv, input logic [4:0] iRsvAddr, input logic [9:0] iRaddr,
                                 input string tag);
        @(negedge clk);
        we       = iWe;
        waddr    = iWaddr;
        wdata    = iWdata;
        rsv      = iRsv;
        rsv_addr = iRsvAddr;
        raddr    = iRaddr;
        #1;
        checkReads(tag);
    endtask

    // Advance one edge; the model applies write-then-reserve so reserve wins.
    task automatic clockEdge();
        @(posedge clk);
        if (rst_n) begin
            if (we && waddr != 0) begin
                mdlMem[waddr]  = wdata;
                mdlPend[waddr] = 1'b0;
            end
            if (rsv && rsv_addr != 0) mdlPend[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic [9:0] iRaddr, input string tag);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, iRaddr, tag);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; rsv = 1'b0; waddr = '0; wdata = '0; rsv_addr = '0;
        raddr = {5'd3, 5'd9};
        mdlReset();
        #2;
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_cnt", 64'(pend_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 5'd10, 32'd10, 1'b0, 5'd0, {5'd0, 5'd0}, "w10");
        clockEdge();
        applyStimulus(1'b1, 5'd20, 32'd20, 1'b0, 5'd0, {5'd0, 5'd0}, "w20");
        clockEdge();
        idle({5'd20, 5'd10}, "rd10_20");
        checkOutput("basic_rd0", 64'(rdata[31:0]), 64'd10);
        checkOutput("basic_rd1", 64'(rdata[63:32]), 64'd20);
        checkOutput("basic_busy", 64'(busy), 64'd0);
        checkOutput("basic_cnt", 64'(pend_cnt), 64'd0);
        clockEdge();

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, {5'd0, 5'd7}, "rsv7");
        clockEdge();
        idle({5'd0, 5'd7}, "pend7");
        checkOutput("rsv7_busy", 64'(busy[0]), 64'd1);
        checkOutput("rsv7_cnt", 64'(pend_cnt), 64'd1);
        clockEdge();
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, {5'd0, 5'd7}, "wr7");
        clockEdge();
        idle({5'd0, 5'd7}, "done7");
        checkOutput("wr7_busy", 64'(busy[0]), 64'd0);
        checkOutput("wr7_rd", 64'(rdata[31:0]), 64'hDEADBEEF);
        checkOutput("wr7_cnt", 64'(pend_cnt), 64'd0);
        clockEdge();

        applyStimulus(1'b1, 5'd3, 32'd5, 1'b1, 5'd3, {5'd0, 5'd3}, "same3");
        clockEdge();
        idle({5'd0, 5'd3}, "after3");
        checkOutput("same3_rd", 64'(rdata[31:0]), 64'd5);
        checkOutput("same3_busy", 64'(busy[0]), 64'd1);
        checkOutput("same3_cnt", 64'(pend_cnt), 64'd1);
        clockEdge();

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, {5'd0, 5'd0}, "zero");
        clockEdge();
        idle({5'd0, 5'd0}, "after0");
        checkOutput("zero_rd", rdata, 64'd0);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_cnt", 64'(pend_cnt), 64'd1);
        clockEdge();

        applyStimulus(1'b1, 5'd12, 32'h11, 1'b1, 5'd12, {5'd0, 5'd0}, "set12");
        clockEdge();
        applyStimulus(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, {5'd12, 5'd0}, "byp12");
`ifdef REG_FILE_BYPASS_EN
        checkOutput("byp_rd1", 64'(rdata[63:32]), 64'h55);
        checkOutput("byp_busy1", 64'(busy[1]), 64'd0);
`else
        checkOutput("byp_rd1", 64'(rdata[63:32]), 64'h11);
        checkOutput("byp_busy1", 64'(busy[1]), 64'd1);
`endif
        clockEdge();

        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa, ra, r0, r1;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? ra : r0;
            if ($urandom_range(0, 3) != 0) r1 = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra,
                          {r1, r0}, "rnd");
            clockEdge();
        end

        applyStimulus(1'b1, 5'd5, 32'hA5A5_0005, 1'b0, 5'd0, {5'd0, 5'd0}, "w5");
        clockEdge();
        applyStimulus(1'b1, 5'd31, 32'hA5A5_001F, 1'b0, 5'd0, {5'd0, 5'd0}, "w31");
        clockEdge();
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), {5'd31, 5'd5}, "rsvall");
            clockEdge();
        end
        checkOutput("full_cnt", 64'(pend_cnt), 64'd31);
        idle({5'd31, 5'd5}, "full");
        checkOutput("full_rd0", 64'(rdata[31:0]), 64'hA5A5_0005);
        #1;
        rst_n = 1'b0;
        #1;
        mdlReset();
        checkOutput("arst_cnt", 64'(pend_cnt), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_rdata", rdata, 64'd0);
        @(posedge clk);
        #1;
        checkReads("inrst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          10'($urandom_range(0, 1023)), "post");
            clockEdge();
        end

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, shall set the address width; depth shall be 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, shall set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, shall make entry 0 hardwired to zero when 1.
REQ-005 Clock and reset shall be: one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 we  input  1  write enable; writes wdata to entry waddr and clears its pending bit.
REQ-009 waddr  input  ADDR_W  write address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 rsv  input  1  reserve enable; marks entry rsv_addr pending (result outstanding).
REQ-012 rsv_addr  input  ADDR_W  reserve address.
REQ-013 raddr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-014 rdata  output  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-015 busy  output  NUM_RD  busy[i] high when entry raddr[i] is pending.
REQ-016 pend_cnt  output  ADDR_W+1  number of entries currently pending.

Function
REQ-017 Reads shall be combinational: rdata[i] shall equal the stored value of entry raddr[i] in the same cycle, zero latency.
REQ-018 Writes shall take effect at the rising clk edge when we=1; new data visible on rdata the following cycle (without bypass, see REQ-027).
REQ-019 Each entry shall own one pending bit; rsv=1 shall set pending[rsv_addr] at the clock edge; we=1 shall clear pending[waddr] at the clock edge.
REQ-020 Simultaneous rsv and we to the same address shall leave the entry pending (reserve wins) while still writing wdata.
REQ-021 Simultaneous rsv and we to different addresses shall both take effect in the same edge.
REQ-022 busy[i] shall be the registered pending bit of raddr[i], combinationally selected.
REQ-023 pend_cnt shall be a registered counter: +1 on set of a non-pending bit, -1 on clear of a pending bit, net 0 when both occur or when reserving an already-pending entry; it shall never wrap (max 2**ADDR_W).
REQ-024 With ZERO_REG=1: writes and reserves to entry 0 shall be ignored; rdata for address 0 shall be 0; busy for address 0 shall be 0.
REQ-025 Multiple read ports addressing the same entry shall return identical data and busy.

Reset
REQ-026 rst_n low shall asynchronously clear all entries to 0, all pending bits to 0 and pend_cnt to 0; rdata and busy shall therefore read 0 during and after reset; writes/reserves coincident with the deasserting edge are ignored until rst_n is sampled high.

Configuration
REQ-027 Macro REG_FILE_BYPASS_EN: when defined, a read with we=1 and waddr==raddr[i] (non-zero when ZERO_REG=1) shall return wdata on rdata[i] and force busy[i]=0 in the same cycle unless rsv to that address is also active; when undefined, rdata[i] returns the old stored value and busy[i] the current pending bit.

Verification
REQ-028 Reset, then we=1 waddr=10 wdata=10, next cycle waddr=20 wdata=20, then we=0 raddr={20,10} -> rdata port0=10, port1=20, busy=0, pend_cnt=0.
REQ-029 rsv=1 rsv_addr=7 for one edge, raddr0=7 -> busy[0]=1, pend_cnt=1; then we=1 waddr=7 wdata=0xDEADBEEF -> next cycle busy[0]=0, rdata0=0xDEADBEEF, pend_cnt=0.
REQ-030 Same-edge rsv=1 rsv_addr=3 and we=1 waddr=3 wdata=5 -> entry 3 reads 5, busy stays 1, pend_cnt=1.
REQ-031 ZERO_REG=1: we=1 waddr=0 wdata=0xFFFFFFFF, rsv_addr=0 -> rdata for addr 0 = 0, busy=0, pend_cnt unchanged.
REQ-032 With REG_FILE_BYPASS_EN: entry 12 pending, we=1 waddr=12 wdata=0x55 while raddr1=12 -> same cycle rdata1=0x55, busy[1]=0; without macro -> rdata1=old value, busy[1]=1.
REQ-033 Reserve entries 1..31 then assert rst_n=0 mid-clock -> pend_cnt, busy and all rdata go 0 immediately without a clock edge.
